// File: rtl/sddr_pkg.sv
// Shared types for the DDR3 command issue stage: opcodes, pin encoding and FSM state codes.
package sddr_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpMrs  = 3'd1,
    OpRef  = 3'd2,
    OpPre  = 3'd3,
    OpAct  = 3'd4,
    OpWr   = 3'd5,
    OpRd   = 3'd6,
    OpZqcl = 3'd7
  } sddr_op_t;

  // Bit order is {ras_n, cas_n, we_n}.
  typedef logic [2:0] sddr_pins_t;

  localparam sddr_pins_t PinsNop = 3'b111;

  typedef logic [2:0] sddr_state_t;

  localparam sddr_state_t StIdle    = 3'd0;
  localparam sddr_state_t StWait    = 3'd1;
  localparam sddr_state_t StArp     = 3'd2;
  localparam sddr_state_t StArpWait = 3'd3;
  localparam sddr_state_t StArf     = 3'd4;
  localparam sddr_state_t StArfWait = 3'd5;

  function automatic sddr_pins_t sddr_encode(sddr_op_t op);
    sddr_pins_t pins;
    unique case (op)
      OpNop:  pins = 3'b111;
      OpMrs:  pins = 3'b000;
      OpRef:  pins = 3'b001;
      OpPre:  pins = 3'b010;
      OpAct:  pins = 3'b011;
      OpWr:   pins = 3'b100;
      OpRd:   pins = 3'b101;
      OpZqcl: pins = 3'b110;
    endcase
    return pins;
  endfunction

  function automatic int unsigned sddr_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sddr_refresh_timer.sv
// Auto-refresh interval counter; raises due_o one cycle after the count reaches zero.
module sddr_refresh_timer #(
  parameter int unsigned T_REFI = 6240,
  parameter int unsigned CntW   = 14
) (
  input  logic ddr_clock_i,
  input  logic ddr_reset_n_i,
  input  logic enable_i,
  input  logic seq_active_i,
  input  logic seq_done_i,
  output logic due_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            due_q, due_d;

  always_comb begin
    cnt_d = cnt_q;
    due_d = due_q;
    // A sequence already under way must finish even if the controller drops CKE.
    if (seq_done_i || (!enable_i && !seq_active_i)) begin
      cnt_d = CntW'(T_REFI);
      due_d = 1'b0;
    end else if (enable_i) begin
      if (cnt_q == '0) begin
        due_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      cnt_q <= CntW'(T_REFI);
      due_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      due_q <= due_d;
    end
  end

  assign due_o = due_q;

endmodule

// File: rtl/sddr_cmd_issue.sv
// DDR3 command issue stage: encodes one accepted command onto registered pins and enforces
// per-command spacing. Define SDDR_AUTO_REFRESH_EN to add periodic PRE-all + REF insertion.
module sddr_cmd_issue
  import sddr_pkg::*;
#(
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned T_RCD     = 6,
  parameter int unsigned T_RP      = 6,
  parameter int unsigned T_RFC     = 88,
  parameter int unsigned T_MOD     = 12,
  parameter int unsigned T_CCD     = 4,
  parameter int unsigned T_ZQ      = 512,
  parameter int unsigned T_REFI    = 6240
) (
  input  logic                 ddr_clock_i,
  input  logic                 ddr_reset_n_i,
  input  logic                 enable_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  sddr_op_t             cmd_op_i,
  input  logic [BANK_BITS-1:0] cmd_bank_i,
  input  logic [ADDR_BITS-1:0] cmd_addr_i,
  output logic                 issued_o,
  output logic                 ref_pending_o,
  output logic                 ddr3_ras_n_o,
  output logic                 ddr3_cas_n_o,
  output logic                 ddr3_we_n_o,
  output logic [BANK_BITS-1:0] ddr3_ba_o,
  output logic [ADDR_BITS-1:0] ddr3_addr_o
);

  localparam int unsigned MaxT = sddr_max(sddr_max(sddr_max(T_RCD, T_RP), sddr_max(T_RFC, T_MOD)),
                                          sddr_max(sddr_max(T_CCD, T_ZQ), T_REFI));
  localparam int unsigned CntW = $clog2(MaxT) + 1;

  sddr_state_t            state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_dec, spacing;
  sddr_pins_t             pins_q, pins_d;
  logic                   issued_q, issued_d;
  logic [BANK_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   ref_pending;
  logic                   accept;

  assign cmd_ready_o = (state_q == StIdle) & enable_i & ~ref_pending;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);

  always_comb begin
    unique case (cmd_op_i)
      OpNop:       spacing = CntW'(1);
      OpMrs:       spacing = CntW'(T_MOD);
      OpRef:       spacing = CntW'(T_RFC);
      OpPre:       spacing = CntW'(T_RP);
      OpAct:       spacing = CntW'(T_RCD);
      OpWr, OpRd:  spacing = CntW'(T_CCD);
      OpZqcl:      spacing = CntW'(T_ZQ);
    endcase
  end

`ifdef SDDR_AUTO_REFRESH_EN
  localparam logic [ADDR_BITS-1:0] PreAllAddr = ADDR_BITS'(1024);

  logic seq_active;
  logic seq_done;

  assign seq_active = (state_q == StArp) || (state_q == StArpWait) ||
                      (state_q == StArf) || (state_q == StArfWait);

  sddr_refresh_timer #(
    .T_REFI (T_REFI),
    .CntW   (CntW)
  ) u_refresh_timer (
    .ddr_clock_i   (ddr_clock_i),
    .ddr_reset_n_i (ddr_reset_n_i),
    .enable_i      (enable_i),
    .seq_active_i  (seq_active),
    .seq_done_i    (seq_done),
    .due_o         (ref_pending)
  );
`else
  assign ref_pending = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pins_d   = PinsNop;
    issued_d = 1'b0;
    ba_d     = ba_q;
    addr_d   = addr_q;
`ifdef SDDR_AUTO_REFRESH_EN
    seq_done = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          pins_d   = sddr_encode(cmd_op_i);
          issued_d = 1'b1;
          ba_d     = cmd_bank_i;
          addr_d   = cmd_addr_i;
          if (spacing > CntW'(1)) begin
            state_d = StWait;
            cnt_d   = spacing - CntW'(1);
          end
        end
`ifdef SDDR_AUTO_REFRESH_EN
        else if (ref_pending && enable_i) begin
          state_d  = StArp;
          cnt_d    = CntW'(T_RP - 1);
          pins_d   = sddr_encode(OpPre);
          issued_d = 1'b1;
          ba_d     = '0;
          addr_d   = PreAllAddr;
        end
`endif
      end
      // Exit one cycle early so ready is back at accept + T.
      StWait: begin
        cnt_d = cnt_dec;
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end
      end
`ifdef SDDR_AUTO_REFRESH_EN
      StArp, StArpWait: begin
        if (cnt_q == '0) begin
          state_d  = StArf;
          cnt_d    = CntW'(T_RFC - 1);
          pins_d   = sddr_encode(OpRef);
          issued_d = 1'b1;
        end else begin
          state_d = StArpWait;
          cnt_d   = cnt_dec;
        end
      end
      StArf, StArfWait: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          seq_done = 1'b1;
        end else begin
          state_d = StArfWait;
          cnt_d   = cnt_dec;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
    if (!ddr_reset_n_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pins_q   <= PinsNop;
      issued_q <= 1'b0;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pins_q   <= pins_d;
      issued_q <= issued_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
    end
  end

  assign {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} = pins_q;
  assign ddr3_ba_o     = ba_q;
  assign ddr3_addr_o   = addr_q;
  assign issued_o      = issued_q;
  assign ref_pending_o = ref_pending;

endmodule
